// File: rtl/wrr_packet_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// wrr_pkg: shared FSM encoding, default sizes and rotating first-set helper.
// Rev 1.0
// ============================================================================
package wrr_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int N_DEF  = 4;
  localparam int W_DEF  = 3;
  localparam int IW_DEF = 2;

  // Index of the first set bit of vec, scanning ptr, ptr+1, ... with wrap.
  function automatic logic [IW_DEF-1:0] rot_first(input logic [N_DEF-1:0] vec,
                                                  input logic [IW_DEF-1:0] ptr);
    logic [IW_DEF-1:0] res;
    logic              hit;
    int                j;
    res = '0;
    hit = 1'b0;
    for (int i = 0; i < N_DEF; i++) begin
      j = (int'(ptr) + i) % N_DEF;
      if (!hit && vec[j]) begin
        res = IW_DEF'(j);
        hit = 1'b1;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wrr_packet_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick: combinational rotating-priority picker (vec, ptr -> idx, found).
// Rev 1.0
// ============================================================================
module rr_pick
  import wrr_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  assign found = |vec;

  if (N == N_DEF && IW == IW_DEF) begin : g_pkg
    assign idx = rot_first(vec, ptr);
  end else begin : g_loop
    always_comb begin
      logic hit;
      int   j;
      idx = '0;
      hit = 1'b0;
      for (int i = 0; i < N; i++) begin
        j = (int'(ptr) + i) % N;
        if (!hit && vec[j]) begin
          idx = IW'(j);
          hit = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wrr_packet_scheduler.sv
`default_nettype none
// ============================================================================
// wrr_packet_scheduler: weighted round-robin whole-packet scheduler and mux.
// Optional stall watchdog: WRR_WATCHDOG_EN.   Rev 1.0
// ============================================================================
module wrr_packet_scheduler
  import wrr_pkg::*;
#(
  parameter int             N      = 4,
  parameter int             DW     = 32,
  parameter int             W      = 3,
  parameter int             IW     = 2,
  parameter logic [N*W-1:0] WT_RST = {3'd4, 3'd2, 3'd1, 3'd1},
  parameter int             TMO    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_valid,
  input  logic [N*DW-1:0] s_data,
  input  logic [N-1:0]    s_last,
  output logic [N-1:0]    s_ready,
  output logic            m_valid,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  input  logic            m_ready,
  output logic [IW-1:0]   m_src,
  output logic [N-1:0]    grant,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [W-1:0]    cfg_weight,
  output logic            tmo_err
);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [W-1:0]  weight [N];
  logic [W-1:0]  credit [N];

  logic [N-1:0]  eligible;
  logic [N-1:0]  enabled;
  logic [N-1:0]  pick_vec;
  logic          reload;
  logic          found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_after;
  logic          xfer_last;

  always_comb begin
    eligible = '0;
    enabled  = '0;
    for (int k = 0; k < N; k++) begin
      eligible[k] = s_valid[k] && (credit[k] != '0);
      enabled[k]  = (weight[k] != '0);
    end
    // Out of credit but someone enabled is asking: refill and pick in the same cycle.
    reload   = (state == IDLE) && (s_valid != '0) && (eligible == '0)
               && ((s_valid & enabled) != '0);
    pick_vec = reload ? (s_valid & enabled) : eligible;
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .vec   (pick_vec),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (found)
  );

  assign m_valid   = |(grant & s_valid);
  assign m_last    = |(grant & s_last);
  assign m_data    = s_data[int'(m_src)*DW +: DW];
  assign s_ready   = grant & {N{m_ready}};
  assign xfer_last = m_valid && m_ready && m_last;
  assign ptr_after = (int'(m_src) == N - 1) ? '0 : m_src + IW'(1);

`ifdef WRR_WATCHDOG_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] stall_cnt;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TMO);
  assign tmo_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      m_src <= '0;
      ptr   <= '0;
      for (int k = 0; k < N; k++) begin
        weight[k] <= WT_RST[k*W +: W];
        credit[k] <= WT_RST[k*W +: W];
      end
`ifdef WRR_WATCHDOG_EN
      stall_cnt <= '0;
      tmo_err   <= 1'b0;
`endif
    end else begin
`ifdef WRR_WATCHDOG_EN
      tmo_err <= 1'b0;
`endif
      if (cfg_we) begin
        weight[cfg_idx] <= cfg_weight;
      end
      case (state)
        IDLE: begin
          if (reload) begin
            for (int k = 0; k < N; k++) begin
              credit[k] <= weight[k];
            end
          end
          if (found) begin
            grant <= N'(1) << pick_idx;
            m_src <= pick_idx;
            state <= BURST;
`ifdef WRR_WATCHDOG_EN
            stall_cnt <= '0;
`endif
          end
        end
        BURST: begin
          if (xfer_last) begin
            credit[m_src] <= (credit[m_src] == '0) ? '0 : credit[m_src] - W'(1);
            ptr           <= ptr_after;
            grant         <= '0;
            state         <= IDLE;
          end
`ifdef WRR_WATCHDOG_EN
          else if (s_valid[m_src]) begin
            stall_cnt <= '0;
          end else if (stall_cnt == CW'(TMO - 1)) begin
            // Abandon the stalled packet: no m_last is ever emitted for it.
            tmo_err       <= 1'b1;
            credit[m_src] <= '0;
            ptr           <= ptr_after;
            grant         <= '0;
            state         <= IDLE;
            stall_cnt     <= '0;
          end else begin
            stall_cnt <= stall_cnt + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wrr_packet_scheduler.sv
`default_nettype none
// ============================================================================
// tb_wrr_packet_scheduler: directed scoreboard bench for wrr_packet_scheduler.
// Rev 1.0
// ============================================================================
module tb_wrr_packet_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int W  = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    s_valid;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_last;
  logic [N-1:0]    s_ready;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic            m_ready;
  logic [IW-1:0]   m_src;
  logic [N-1:0]    grant;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  logic [W-1:0]    cfg_weight;
  logic            tmo_err;

  always #5 clk = ~clk;

  wrr_packet_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .m_src      (m_src),
    .grant      (grant),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_weight (cfg_weight),
    .tmo_err    (tmo_err)
  );

  typedef struct packed {
    logic [IW-1:0] src;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int errors = 0;
  int remaining[N];
  int plen[N];
  int beat[N];
  int pkt[N];
  int exp_pkt[N];
  logic [N-1:0] stall;
  logic toggle;
  int xfers = 0;
  int tmo_pulses = 0;
  int ord1[8] = '{0, 1, 2, 3, 2, 3, 3, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      s_valid[k]           = (remaining[k] > 0) && !stall[k];
      s_data[k*DW +: DW]   = {8'(k), 8'(pkt[k]), 16'(beat[k])};
      s_last[k]            = (beat[k] == plen[k] - 1);
    end
  endtask

  task automatic push_pkt(input int k, input int len);
    beat_t e;
    for (int b = 0; b < len; b++) begin
      e.src  = IW'(k);
      e.data = {8'(k), 8'(exp_pkt[k]), 16'(b)};
      e.last = (b == len - 1);
      q.push_back(e);
    end
    exp_pkt[k]++;
  endtask

  task automatic tick();
    logic [N-1:0] hs;
    beat_t e;
    @(negedge clk);
    hs = s_valid & s_ready;
    if (!rst && m_valid && m_ready) begin
      xfers++;
      chk("xfer_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("beat", {m_src, m_data, m_last}, e);
      end
    end
    if (tmo_err) tmo_pulses++;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        if (beat[k] == plen[k] - 1) begin
          beat[k] = 0;
          pkt[k]++;
          remaining[k]--;
        end else begin
          beat[k]++;
        end
      end
    end
    if (toggle) m_ready = ~m_ready;
    drive();
    #1;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && q.size() > 0; i++) tick();
    chk(tag, 64'(q.size()), 64'd0);
  endtask

  task automatic reinit_sources();
    q.delete();
    stall = '0;
    for (int k = 0; k < N; k++) begin
      remaining[k] = 0;
      plen[k]      = 1;
      beat[k]      = 0;
      pkt[k]       = exp_pkt[k];
    end
    drive();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int x0;
    toggle     = 1'b0;
    m_ready    = 1'b1;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_weight = '0;
    for (int k = 0; k < N; k++) exp_pkt[k] = 0;
    reinit_sources();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_src", 64'(m_src), 64'd0);
    chk("rst_tmo_err", 64'(tmo_err), 64'd0);

    // Four sources, single-beat packets, two full weighted rounds.
    remaining = '{2, 2, 4, 8};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) push_pkt(ord1[i], 1);
    x0 = xfers;
    drive();
    tick();
    chk("t1_first_grant", 64'(grant), 64'b0001);
    wait_drain("t1_drain", 100);
    chk("t1_count", 64'(xfers - x0), 64'd16);

    // Lone src2 at weight 1: each packet needs a same-cycle reload.
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_weight = 3'd1;
    tick();
    cfg_we = 1'b0;
    remaining[2] = 3;
    for (int i = 0; i < 3; i++) push_pkt(2, 1);
    drive();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_grant_pattern", 64'(grant), (i % 2 == 0) ? 64'b0100 : 64'b0000);
    end
    chk("t2_drain", 64'(q.size()), 64'd0);

    // src1 three-beat packet under a toggling m_ready.
    plen[1] = 3; remaining[1] = 1;
    push_pkt(1, 3);
    x0 = xfers;
    toggle = 1'b1;
    drive();
    tick();
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      chk("t3_grant_held", 64'(grant), 64'b0010);
      chk("t3_s_ready", 64'(s_ready), m_ready ? 64'b0010 : 64'b0000);
      tick();
    end
    toggle = 1'b0; m_ready = 1'b1;
    chk("t3_drain", 64'(q.size()), 64'd0);
    chk("t3_count", 64'(xfers - x0), 64'd3);
    chk("t3_bubble_grant", 64'(grant), 64'd0);
    chk("t3_bubble_valid", 64'(m_valid), 64'd0);

    // Disable src0 while it requests: only its remaining credit is spent.
    remaining[0] = 5;
    push_pkt(0, 1);
    x0 = xfers;
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_weight = 3'd0;
    drive();
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i >= 20) chk("t4_grant_idle", 64'(grant), 64'd0);
    end
    chk("t4_count", 64'(xfers - x0), 64'd1);
    remaining[0] = 0;
    drive();

    // Reset in the middle of a src3 four-beat packet.
    plen[3] = 4; remaining[3] = 1;
    push_pkt(3, 4);
    drive();
    tick();
    chk("t5_grant", 64'(grant), 64'b1000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_grant", 64'(grant), 64'd0);
    chk("t5_rst_m_valid", 64'(m_valid), 64'd0);
    chk("t5_rst_s_ready", 64'(s_ready), 64'd0);
    chk("t5_rst_m_src", 64'(m_src), 64'd0);
    reinit_sources();

    // Credits and weights back at reset values: same round order as before.
    remaining = '{1, 1, 2, 4};
    for (int i = 0; i < 8; i++) push_pkt(ord1[i], 1);
    drive();
    wait_drain("t5_round_drain", 60);

    // src3 stalls after its first beat.
    plen[3] = 2; remaining[3] = 1;
    push_pkt(3, 2);
    drive();
    tick();
    chk("t6_grant", 64'(grant), 64'b1000);
    tick();
    stall[3] = 1'b1;
    drive();
    tmo_pulses = 0;
`ifdef WRR_WATCHDOG_EN
    for (int i = 0; i < 15; i++) tick();
    chk("t6_pre_tmo_grant", 64'(grant), 64'b1000);
    chk("t6_pre_tmo_err", 64'(tmo_err), 64'd0);
    tick();
    chk("t6_tmo_err", 64'(tmo_err), 64'd1);
    chk("t6_tmo_grant", 64'(grant), 64'd0);
    tick();
    chk("t6_tmo_pulse_end", 64'(tmo_err), 64'd0);
    chk("t6_tmo_once", 64'(tmo_pulses), 64'd1);
    reinit_sources();
    remaining[0] = 1; remaining[2] = 1;
    push_pkt(0, 1);
    push_pkt(2, 1);
    drive();
    wait_drain("t6_after_tmo_drain", 20);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_grant_held", 64'(grant), 64'b1000);
      chk("t6_m_valid_low", 64'(m_valid), 64'd0);
    end
    chk("t6_no_tmo", 64'(tmo_pulses), 64'd0);
    stall[3] = 1'b0;
    drive();
    wait_drain("t6_resume_drain", 10);
    chk("t6_end_grant", 64'(grant), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
